// File: rtl/warp_scheduler.sv
// warp_scheduler: splits a dispatched block into warps of NUM_THREADS lanes and
// time-multiplexes them round-robin through the shared core pipeline
// (FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE). Memory instructions park the warp
// in WAIT until every enabled lane's LSU is done; RET retires only the current warp.
module warp_scheduler #(
   parameter int NUM_THREADS = 4,
   parameter int MAX_WARPS   = 4,
   parameter int ID_W        = 8,
   parameter int WID_W       = $clog2(MAX_WARPS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        core_start,
   input  logic [ID_W-1:0]             core_block_id,
   input  logic [ID_W-1:0]             core_thread_count,
   input  logic [2*NUM_THREADS-1:0]    lsu_state_flat,
   input  logic                        decoded_mem,
   input  logic                        decoded_ret,
   output logic [2:0]                  core_state,
   output logic                        core_done,
   output logic [ID_W-1:0]             block_id,
   output logic [ID_W-1:0]             threads_per_block,
   output logic [WID_W-1:0]            warp_id,
   output logic [NUM_THREADS-1:0]      thread_enable,
   output logic [NUM_THREADS*ID_W-1:0] thread_id_flat
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_FETCH   = 3'b001,
      S_DECODE  = 3'b010,
      S_REQUEST = 3'b011,
      S_WAIT    = 3'b100,
      S_EXECUTE = 3'b101,
      S_UPDATE  = 3'b110
   } state_e;

   // Capacity and lane count widened by one bit so the clamp and the tail-lane
   // compare cannot wrap at the top of the ID_W range.
   localparam logic [ID_W:0] MAX_T = (ID_W+1)'(MAX_WARPS * NUM_THREADS);
   localparam logic [ID_W:0] NT_W  = (ID_W+1)'(NUM_THREADS);

   state_e                 state_q, state_d;
   logic                   done_q, done_d;
   logic [ID_W-1:0]        bid_q, bid_d;
   logic [ID_W-1:0]        tpb_q, tpb_d;
   logic [WID_W-1:0]       wid_q, wid_d;
   logic [MAX_WARPS-1:0]   mask_q, mask_d;

   logic [ID_W:0]          cnt_ext;
   logic [ID_W:0]          tpb_start;
   logic [MAX_WARPS-1:0]   start_mask;

   logic [ID_W:0]                      warp_base;
   logic [NUM_THREADS-1:0][ID_W:0]     lane_tid;
   logic [NUM_THREADS-1:0]             lane_done;
   logic                               wait_done;

   logic [MAX_WARPS-1:0]   mask_after;
   logic [WID_W-1:0]       rr_next;
   logic                   rr_found;
   int                     rr_idx;

   // Clamp the requested thread count and derive which warps the block occupies.
   // A warp is present when its first thread id falls below the clamped count,
   // which is the same as w < ceil(count / NUM_THREADS) without a divider.
   always_comb begin
      cnt_ext    = {1'b0, core_thread_count};
      tpb_start  = (cnt_ext > MAX_T) ? MAX_T : cnt_ext;
      start_mask = '0;
      for (int w = 0; w < MAX_WARPS; w++)
         start_mask[w] = (((ID_W+1)'(w)) * NT_W) < tpb_start;
   end

   assign warp_base = ((ID_W+1)'(wid_q)) * NT_W;

   // Per-lane thread ids, tail masking and LSU completion for the current warp.
   always_comb begin
      thread_id_flat = '0;
      thread_enable  = '0;
      lane_tid       = '0;
      lane_done      = '0;
      for (int l = 0; l < NUM_THREADS; l++) begin
         lane_tid[l]                        = warp_base + (ID_W+1)'(l);
         thread_id_flat[l*ID_W +: ID_W]     = lane_tid[l][ID_W-1:0];
         thread_enable[l]                   = (state_q != S_IDLE) && (lane_tid[l] < {1'b0, tpb_q});
         lane_done[l]                       = (lsu_state_flat[2*l +: 2] == 2'b11);
      end
   end

   // Disabled lanes never hold up WAIT; they may have no LSU activity at all.
   assign wait_done = &(lane_done | ~thread_enable);

   // Round-robin pick starting after the current warp; the current warp comes
   // last in the search so it is reselected only when it is the sole survivor.
   always_comb begin
      mask_after = mask_q;
      if (decoded_ret)
         mask_after[wid_q] = 1'b0;
      rr_next  = wid_q;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int k = 1; k <= MAX_WARPS; k++) begin
         rr_idx = int'(wid_q) + k;
         if (rr_idx >= MAX_WARPS)
            rr_idx = rr_idx - MAX_WARPS;
         if (!rr_found && mask_after[WID_W'(rr_idx)]) begin
            rr_found = 1'b1;
            rr_next  = WID_W'(rr_idx);
         end
      end
   end

   // Pipeline sequencing, block accept and warp retirement.
   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      bid_d   = bid_q;
      tpb_d   = tpb_q;
      wid_d   = wid_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE: begin
            if (core_start) begin
               bid_d  = core_block_id;
               tpb_d  = tpb_start[ID_W-1:0];
               mask_d = start_mask;
               wid_d  = '0;
               // An empty block completes on the spot without touching the pipeline.
               if (tpb_start == '0) begin
                  done_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH:   state_d = S_DECODE;
         S_DECODE:  state_d = S_REQUEST;
         S_REQUEST: state_d = decoded_mem ? S_WAIT : S_EXECUTE;
         S_WAIT:    if (wait_done) state_d = S_EXECUTE;
         S_EXECUTE: state_d = S_UPDATE;
         S_UPDATE: begin
            mask_d = mask_after;
            wid_d  = rr_next;
            if (!rr_found) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_FETCH;
            end
         end
         default:   state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any block in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         bid_q   <= '0;
         tpb_q   <= '0;
         wid_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         bid_q   <= bid_d;
         tpb_q   <= tpb_d;
         wid_q   <= wid_d;
         mask_q  <= mask_d;
      end
   end

   assign core_state        = state_q;
   assign core_done         = done_q;
   assign block_id          = bid_q;
   assign threads_per_block = tpb_q;
   assign warp_id           = wid_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: drives warp_scheduler like the core's decoder/LSUs would and
// checks it against a block-level model (active-warp set, round-robin pick,
// lane arithmetic, WAIT length = slowest enabled lane).
module tb_warp_scheduler;
   localparam int NT  = 4;
   localparam int MW  = 4;
   localparam int IDW = 8;
   localparam int WW  = 2;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_REQ = 3'd3,
                          ST_WAIT = 3'd4, ST_EXEC = 3'd5, ST_UPD = 3'd6;

   logic              clk = 1'b0;
   logic              reset;
   logic              core_start;
   logic [IDW-1:0]    core_block_id;
   logic [IDW-1:0]    core_thread_count;
   logic [2*NT-1:0]   lsu_state_flat;
   logic              decoded_mem;
   logic              decoded_ret;
   logic [2:0]        core_state;
   logic              core_done;
   logic [IDW-1:0]    block_id;
   logic [IDW-1:0]    threads_per_block;
   logic [WW-1:0]     warp_id;
   logic [NT-1:0]     thread_enable;
   logic [NT*IDW-1:0] thread_id_flat;

   warp_scheduler #(.NUM_THREADS(NT), .MAX_WARPS(MW), .ID_W(IDW)) dut (
      .clk(clk), .reset(reset), .core_start(core_start), .core_block_id(core_block_id),
      .core_thread_count(core_thread_count), .lsu_state_flat(lsu_state_flat),
      .decoded_mem(decoded_mem), .decoded_ret(decoded_ret), .core_state(core_state),
      .core_done(core_done), .block_id(block_id), .threads_per_block(threads_per_block),
      .warp_id(warp_id), .thread_enable(thread_enable), .thread_id_flat(thread_id_flat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model of the block in flight.
   int exp_tpb;
   int exp_wid;
   bit exp_mask[MW];
   int lsu_dly[NT];

   function automatic logic [NT-1:0] exp_en();
      logic [NT-1:0] e;
      for (int l = 0; l < NT; l++) e[l] = (exp_wid * NT + l) < exp_tpb;
      return e;
   endfunction

   function automatic logic [NT*IDW-1:0] exp_tids();
      logic [NT*IDW-1:0] t;
      for (int l = 0; l < NT; l++) t[l*IDW +: IDW] = IDW'(exp_wid * NT + l);
      return t;
   endfunction

   function automatic int rr_pick(input int cur);
      for (int k = 1; k <= MW; k++)
         if (exp_mask[(cur + k) % MW]) return (cur + k) % MW;
      return -1;
   endfunction

   function automatic bit any_active();
      for (int w = 0; w < MW; w++) if (exp_mask[w]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic apply_reset();
      reset = 1'b1; core_start = 1'b0; core_block_id = '0; core_thread_count = '0;
      lsu_state_flat = '0; decoded_mem = 1'b0; decoded_ret = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Accept a block from IDLE; returns at the negedge after the start cycle.
   task automatic start_block(input int cnt, input int bid);
      core_start = 1'b1; core_thread_count = IDW'(cnt); core_block_id = IDW'(bid);
      @(negedge clk);
      core_start = 1'b0;
      exp_tpb = (cnt > NT * MW) ? NT * MW : cnt;
      for (int w = 0; w < MW; w++) exp_mask[w] = (w * NT) < exp_tpb;
      exp_wid = 0;
      checks++; if (block_id !== IDW'(bid)) begin errors++; $display("FAIL start_block_id got %0d want %0d", block_id, bid); end
      checks++; if (threads_per_block !== IDW'(exp_tpb)) begin errors++; $display("FAIL start_tpb got %0d want %0d", threads_per_block, exp_tpb); end
      checks++; if (core_done !== (exp_tpb == 0)) begin errors++; $display("FAIL start_done got %b want %b", core_done, exp_tpb == 0); end
      checks++; if (core_state !== ((exp_tpb == 0) ? ST_IDLE : ST_FETCH)) begin errors++; $display("FAIL start_state got %0d want %0d", core_state, (exp_tpb == 0) ? 0 : 1); end
   endtask

   // One warp trip through the pipeline, entered at a FETCH negedge; leaves at
   // the negedge of the following FETCH (or IDLE once the block is finished).
   task automatic run_slot(input bit mem, input bit ret);
      int waits, want_waits, nxt, cyc;
      logic [NT-1:0] en;
      en = exp_en();
      want_waits = 0;
      if (mem) for (int l = 0; l < NT; l++) if (en[l] && lsu_dly[l] > want_waits) want_waits = lsu_dly[l];
      checks++; if (core_state !== ST_FETCH) begin errors++; $display("FAIL slot_fetch state got %0d want 1", core_state); end
      checks++; if (warp_id !== WW'(exp_wid)) begin errors++; $display("FAIL slot_warp_id got %0d want %0d", warp_id, exp_wid); end
      checks++; if (thread_enable !== en) begin errors++; $display("FAIL slot_enable got %b want %b", thread_enable, en); end
      checks++; if (thread_id_flat !== exp_tids()) begin errors++; $display("FAIL slot_tids got %h want %h", thread_id_flat, exp_tids()); end
      checks++; if (core_done !== 1'b0) begin errors++; $display("FAIL slot_done_low got %b want 0", core_done); end
      cyc = 0;
      @(negedge clk); cyc++;
      checks++; if (core_state !== ST_DECODE) begin errors++; $display("FAIL slot_decode got %0d want 2", core_state); end
      @(negedge clk); cyc++;
      checks++; if (core_state !== ST_REQ) begin errors++; $display("FAIL slot_request got %0d want 3", core_state); end
      decoded_mem = mem;
      @(negedge clk); cyc++;
      waits = 0;
      while (core_state === ST_WAIT && waits < 300) begin
         waits++;
         for (int l = 0; l < NT; l++) if (lsu_dly[l] <= waits) lsu_state_flat[2*l +: 2] = 2'b11;
         @(negedge clk); cyc++;
      end
      checks++; if (waits !== want_waits) begin errors++; $display("FAIL slot_wait_len got %0d want %0d", waits, want_waits); end
      checks++; if (core_state !== ST_EXEC) begin errors++; $display("FAIL slot_execute got %0d want 5", core_state); end
      lsu_state_flat = '0; decoded_mem = 1'b0;
      @(negedge clk); cyc++;
      checks++; if (core_state !== ST_UPD) begin errors++; $display("FAIL slot_update got %0d want 6", core_state); end
      decoded_ret = ret;
      if (ret) exp_mask[exp_wid] = 1'b0;
      nxt = rr_pick(exp_wid);
      @(negedge clk); cyc++;
      decoded_ret = 1'b0;
      checks++; if (cyc !== 5 + want_waits) begin errors++; $display("FAIL slot_period got %0d want %0d", cyc, 5 + want_waits); end
      if (nxt < 0) begin
         checks++; if (core_state !== ST_IDLE) begin errors++; $display("FAIL block_end_state got %0d want 0", core_state); end
         checks++; if (core_done !== 1'b1) begin errors++; $display("FAIL block_end_done got %b want 1", core_done); end
         checks++; if (thread_enable !== '0) begin errors++; $display("FAIL block_end_enable got %b want 0", thread_enable); end
      end else begin
         exp_wid = nxt;
         checks++; if (core_state !== ST_FETCH) begin errors++; $display("FAIL slot_next_fetch got %0d want 1", core_state); end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (core_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", core_state); end
      checks++; if (core_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", core_done); end
      checks++; if (block_id !== '0 || threads_per_block !== '0) begin errors++; $display("FAIL reset_ids got %0d/%0d want 0/0", block_id, threads_per_block); end
      checks++; if (warp_id !== '0 || thread_enable !== '0) begin errors++; $display("FAIL reset_warp got %0d/%b want 0/0", warp_id, thread_enable); end
   endtask

   task automatic test_two_warps();
      int seq[4];
      lsu_dly = '{1, 1, 1, 1};
      start_block(6, 11);
      for (int i = 0; i < 4; i++) begin
         seq[i] = int'(warp_id);
         run_slot(1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (seq[i] !== (i % 2)) begin errors++; $display("FAIL two_warps_seq[%0d] got %0d want %0d", i, seq[i], i % 2); end
      end
      apply_reset();
   endtask

   task automatic test_wait_stagger();
      lsu_dly = '{2, 5, 3, 7};
      start_block(4, 5);
      run_slot(1'b1, 1'b1);
   endtask

   task automatic test_tail_wait();
      start_block(5, 9);
      lsu_dly = '{1000, 1000, 1000, 1000};
      run_slot(1'b0, 1'b0);
      lsu_dly = '{3, 1000, 1000, 1000};
      run_slot(1'b1, 1'b0);
      run_slot(1'b0, 1'b1);
      run_slot(1'b0, 1'b1);
   endtask

   task automatic test_ret_order();
      int order[4] = '{2, 0, 3, 1};
      int k = 0;
      start_block(16, 42);
      for (int s = 0; s < 40 && k < 4; s++) begin
         if (exp_wid == order[k]) begin run_slot(1'b0, 1'b1); k++; end
         else run_slot(1'b0, 1'b0);
      end
      checks++; if (k !== 4) begin errors++; $display("FAIL ret_order_count got %0d want 4", k); end
      repeat (3) @(negedge clk);
      checks++; if (core_done !== 1'b1 || core_state !== ST_IDLE) begin errors++; $display("FAIL ret_done_hold got %b/%0d want 1/0", core_done, core_state); end
      start_block(4, 1);
      apply_reset();
   endtask

   task automatic test_zero_clamp();
      start_block(0, 77);
      @(negedge clk);
      checks++; if (core_done !== 1'b1 || core_state !== ST_IDLE) begin errors++; $display("FAIL zero_hold got %b/%0d want 1/0", core_done, core_state); end
      start_block(200, 3);
      for (int i = 0; i < 4; i++) run_slot(1'b0, 1'b0);
      checks++; if (warp_id !== 2'd0) begin errors++; $display("FAIL clamp_wrap got %0d want 0", warp_id); end
      apply_reset();
   endtask

   task automatic test_reset_mid_and_ignored_start();
      start_block(8, 7);
      core_start = 1'b1; core_thread_count = 8'd3; core_block_id = 8'd99;
      @(negedge clk);
      core_start = 1'b0;
      checks++; if (core_state !== ST_DECODE || block_id !== 8'd7) begin errors++; $display("FAIL ignore_start_fetch got %0d/%0d want 2/7", core_state, block_id); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (core_state !== ST_EXEC) begin errors++; $display("FAIL ignore_start_exec got %0d want 5", core_state); end
      core_start = 1'b1;
      @(negedge clk);
      core_start = 1'b0;
      checks++; if (core_state !== ST_UPD || threads_per_block !== 8'd8 || block_id !== 8'd7) begin errors++; $display("FAIL ignore_start_update got %0d/%0d/%0d want 6/8/7", core_state, threads_per_block, block_id); end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      decoded_mem = 1'b1;
      @(negedge clk);
      checks++; if (core_state !== ST_WAIT) begin errors++; $display("FAIL mid_reset_wait got %0d want 4", core_state); end
      #2 reset = 1'b1;
      #1;
      checks++; if (core_state !== ST_IDLE || core_done !== 1'b0 || block_id !== '0 || threads_per_block !== '0 || warp_id !== '0 || thread_enable !== '0)
         begin errors++; $display("FAIL mid_reset_async got st=%0d done=%b bid=%0d tpb=%0d wid=%0d en=%b want all 0", core_state, core_done, block_id, threads_per_block, warp_id, thread_enable); end
      @(negedge clk);
      reset = 1'b0; decoded_mem = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (core_done !== 1'b0 || core_state !== ST_IDLE) begin errors++; $display("FAIL mid_reset_no_done got %b/%0d want 0/0", core_done, core_state); end
   endtask

   task automatic test_random();
      for (int b = 0; b < 25; b++) begin
         start_block($urandom_range(1, 20), $urandom_range(0, 255));
         for (int s = 0; s < 60 && any_active(); s++) begin
            for (int l = 0; l < NT; l++) lsu_dly[l] = $urandom_range(1, 6);
            run_slot(1'($urandom % 2), ($urandom % 3) == 0);
         end
         if (any_active()) apply_reset();
      end
   endtask

   initial begin
      test_reset();
      test_two_warps();
      test_wait_stagger();
      test_tail_wait();
      test_ret_order();
      test_zero_clamp();
      test_reset_mid_and_ignored_start();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
